// File: rtl/behav_counter.sv
// Prescaled up/down 8-bit counter with masked parallel load, a combinational
// terminal-count flag and a stretched carry/borrow pulse.
module behav_counter #(
  parameter int DATA_WIDTH = 1,
  parameter int KEEP_WIDTH = 1,
  parameter int HDR_WIDTH  = 1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [7:0] d,
  input  logic       load,
  input  logic [7:0] load_b,
  input  logic       up_down,
  output logic [7:0] qd,
  output logic       qd_b,
  output logic       qd_c
);

  localparam logic [7:0] STEP     = 8'(DATA_WIDTH);
  localparam logic [8:0] PSC_LAST = 9'(HDR_WIDTH - 1);
  localparam logic [3:0] KEEP     = 4'(KEEP_WIDTH);

  // Result carries the wrap flag in bit 8 and the new count in bits 7:0.
  function automatic logic [8:0] step_up(input logic [7:0] v);
    return {1'b0, v} + {1'b0, STEP};
  endfunction

  function automatic logic [8:0] step_dn(input logic [7:0] v);
    return {(v < STEP), 8'(v - STEP)};
  endfunction

  logic [7:0] qd_q,   qd_d;
  logic [8:0] psc_q,  psc_d;
  logic [3:0] hold_q, hold_d;
  logic       qd_c_q, qd_c_d;
  logic       tick;
  logic       wrap;
  logic [8:0] next_val;

  always_comb begin
    tick     = (psc_q == PSC_LAST);
    next_val = up_down ? step_up(qd_q) : step_dn(qd_q);
    qd_d     = qd_q;
    psc_d    = 9'(psc_q + 9'd1);
    wrap     = 1'b0;
    hold_d   = (hold_q != 4'd0) ? 4'(hold_q - 4'd1) : 4'd0;

    if (load) begin
      qd_d  = (d & load_b) | (qd_q & ~load_b);
      psc_d = 9'd0;
    end else if (tick) begin
      qd_d  = next_val[7:0];
      wrap  = next_val[8];
      psc_d = 9'd0;
    end

    // A fresh wrap restarts the stretch even if one is already running.
    if (wrap) hold_d = KEEP;
    qd_c_d = (hold_d != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      qd_q   <= 8'h00;
      psc_q  <= 9'd0;
      hold_q <= 4'd0;
      qd_c_q <= 1'b0;
    end else begin
      qd_q   <= qd_d;
      psc_q  <= psc_d;
      hold_q <= hold_d;
      qd_c_q <= qd_c_d;
    end
  end

  assign qd   = qd_q;
  assign qd_c = qd_c_q;
  assign qd_b = up_down ? ({1'b0, qd_q} > (9'd255 - {1'b0, STEP})) : (qd_q < STEP);

endmodule

// File: tb/tb_behav_counter.sv
// Directed bench: instance A uses default parameters, instance B uses
// HDR_WIDTH=4, DATA_WIDTH=3, KEEP_WIDTH=3 for prescale and stretch behaviour.
module tb_behav_counter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear_a, load_a, up_a;
  logic [7:0] d_a, lb_a, qd_a;
  logic       qdb_a, qdc_a;

  logic       clear_b, load_b_r, up_b;
  logic [7:0] d_b, lb_b, qd_b_o;
  logic       qdb_b, qdc_b;

  int checks   = 0;
  int failures = 0;

  behav_counter u_a (
    .clk(clk), .clear(clear_a), .d(d_a), .load(load_a), .load_b(lb_a),
    .up_down(up_a), .qd(qd_a), .qd_b(qdb_a), .qd_c(qdc_a)
  );

  behav_counter #(.DATA_WIDTH(3), .KEEP_WIDTH(3), .HDR_WIDTH(4)) u_b (
    .clk(clk), .clear(clear_b), .d(d_b), .load(load_b_r), .load_b(lb_b),
    .up_down(up_b), .qd(qd_b_o), .qd_b(qdb_b), .qd_c(qdc_b)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    clear_a = 1; load_a = 0; up_a = 1; d_a = 8'h5A; lb_a = 8'h00;
    clear_b = 1; load_b_r = 0; up_b = 1; d_b = 8'h00; lb_b = 8'h00;
    step(1);
    checks++; if (qd_a !== 8'h00) begin failures++; $display("FAIL reset_qd got=%h exp=00", qd_a); end
    checks++; if (qdc_a !== 1'b0) begin failures++; $display("FAIL reset_qdc got=%b exp=0", qdc_a); end
    checks++; if (qdb_a !== 1'b0) begin failures++; $display("FAIL reset_qdb_up got=%b exp=0", qdb_a); end
    up_a = 0; #1;
    checks++; if (qdb_a !== 1'b1) begin failures++; $display("FAIL reset_qdb_down got=%b exp=1", qdb_a); end
    up_a = 1;
  endtask

  task automatic test_count_up;
    clear_a = 1; step(1);
    clear_a = 0; up_a = 1;
    for (int i = 1; i <= 5; i++) begin
      step(1);
      checks++; if (qd_a !== 8'(i)) begin failures++; $display("FAIL count_up_qd[%0d] got=%h exp=%h", i, qd_a, 8'(i)); end
      checks++; if (qdc_a !== 1'b0) begin failures++; $display("FAIL count_up_qdc[%0d] got=%b exp=0", i, qdc_a); end
    end
  endtask

  task automatic test_load_wrap;
    logic [7:0] exp_q [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic       exp_b [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_c [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    up_a = 1; load_a = 1; d_a = 8'hFE; lb_a = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      step(1);
      load_a = 0;
      checks++; if (qd_a !== exp_q[i]) begin failures++; $display("FAIL load_wrap_qd[%0d] got=%h exp=%h", i, qd_a, exp_q[i]); end
      checks++; if (qdb_a !== exp_b[i]) begin failures++; $display("FAIL load_wrap_qdb[%0d] got=%b exp=%b", i, qdb_a, exp_b[i]); end
      checks++; if (qdc_a !== exp_c[i]) begin failures++; $display("FAIL load_wrap_qdc[%0d] got=%b exp=%b", i, qdc_a, exp_c[i]); end
    end
  endtask

  task automatic test_down_wrap;
    clear_a = 1; step(1);
    clear_a = 0; up_a = 0; #1;
    checks++; if (qdb_a !== 1'b1) begin failures++; $display("FAIL down_qdb_before got=%b exp=1", qdb_a); end
    step(1);
    checks++; if (qd_a !== 8'hFF) begin failures++; $display("FAIL down_qd got=%h exp=FF", qd_a); end
    checks++; if (qdc_a !== 1'b1) begin failures++; $display("FAIL down_qdc got=%b exp=1", qdc_a); end
    checks++; if (qdb_a !== 1'b0) begin failures++; $display("FAIL down_qdb_after got=%b exp=0", qdb_a); end
    step(1);
    checks++; if (qd_a !== 8'hFE) begin failures++; $display("FAIL down_qd2 got=%h exp=FE", qd_a); end
    checks++; if (qdc_a !== 1'b0) begin failures++; $display("FAIL down_qdc2 got=%b exp=0", qdc_a); end
  endtask

  task automatic test_mask_load;
    load_a = 1; d_a = 8'hA5; lb_a = 8'hFF; step(1);
    checks++; if (qd_a !== 8'hA5) begin failures++; $display("FAIL mask_full got=%h exp=A5", qd_a); end
    d_a = 8'h0F; lb_a = 8'hF0; step(1);
    checks++; if (qd_a !== 8'h05) begin failures++; $display("FAIL mask_hi got=%h exp=05", qd_a); end
    d_a = 8'hFF; lb_a = 8'h00; step(1);
    checks++; if (qd_a !== 8'h05) begin failures++; $display("FAIL mask_none got=%h exp=05", qd_a); end
    checks++; if (qdc_a !== 1'b0) begin failures++; $display("FAIL mask_qdc got=%b exp=0", qdc_a); end
    load_a = 0;
  endtask

  task automatic test_clear_priority;
    load_a = 1; d_a = 8'h40; lb_a = 8'hFF; step(1);
    clear_a = 1; d_a = 8'h77; step(1);
    checks++; if (qd_a !== 8'h00) begin failures++; $display("FAIL clr_load_qd got=%h exp=00", qd_a); end
    checks++; if (qdc_a !== 1'b0) begin failures++; $display("FAIL clr_load_qdc got=%b exp=0", qdc_a); end
    clear_a = 0; load_a = 0; up_a = 1; step(1);
    checks++; if (qd_a !== 8'h01) begin failures++; $display("FAIL clr_load_next got=%h exp=01", qd_a); end
  endtask

  task automatic test_prescale;
    clear_b = 0; up_b = 1; load_b_r = 1; d_b = 8'hFD; lb_b = 8'hFF;
    step(1);
    load_b_r = 0;
    checks++; if (qd_b_o !== 8'hFD) begin failures++; $display("FAIL pre_load got=%h exp=FD", qd_b_o); end
    checks++; if (qdb_b !== 1'b1) begin failures++; $display("FAIL pre_qdb got=%b exp=1", qdb_b); end
    for (int i = 1; i <= 3; i++) begin
      step(1);
      checks++; if (qd_b_o !== 8'hFD) begin failures++; $display("FAIL pre_hold[%0d] got=%h exp=FD", i, qd_b_o); end
      checks++; if (qdc_b !== 1'b0) begin failures++; $display("FAIL pre_hold_qdc[%0d] got=%b exp=0", i, qdc_b); end
    end
    step(1);
    checks++; if (qd_b_o !== 8'h00) begin failures++; $display("FAIL pre_wrap got=%h exp=00", qd_b_o); end
    checks++; if (qdb_b !== 1'b0) begin failures++; $display("FAIL pre_wrap_qdb got=%b exp=0", qdb_b); end
    // Direction toggles between ticks must not disturb the count.
    for (int i = 1; i <= 3; i++) begin
      up_b = (i == 3);
      checks++; if (qdc_b !== 1'b1) begin failures++; $display("FAIL stretch_hi[%0d] got=%b exp=1", i, qdc_b); end
      step(1);
      checks++; if (qd_b_o !== 8'h00) begin failures++; $display("FAIL between_ticks[%0d] got=%h exp=00", i, qd_b_o); end
    end
    checks++; if (qdc_b !== 1'b0) begin failures++; $display("FAIL stretch_end got=%b exp=0", qdc_b); end
    step(1);
    checks++; if (qd_b_o !== 8'h03) begin failures++; $display("FAIL pre_tick2 got=%h exp=03", qd_b_o); end
    up_b = 0; step(4);
    checks++; if (qd_b_o !== 8'h00) begin failures++; $display("FAIL down_exact got=%h exp=00", qd_b_o); end
    checks++; if (qdc_b !== 1'b0) begin failures++; $display("FAIL down_exact_qdc got=%b exp=0", qdc_b); end
    step(4);
    checks++; if (qd_b_o !== 8'hFD) begin failures++; $display("FAIL down_wrap_b got=%h exp=FD", qd_b_o); end
    checks++; if (qdc_b !== 1'b1) begin failures++; $display("FAIL down_wrap_qdc got=%b exp=1", qdc_b); end
    clear_b = 1; step(1);
    checks++; if (qdc_b !== 1'b0) begin failures++; $display("FAIL clr_mid_hold got=%b exp=0", qdc_b); end
    checks++; if (qd_b_o !== 8'h00) begin failures++; $display("FAIL clr_mid_qd got=%h exp=00", qd_b_o); end
    clear_b = 0; up_b = 1; step(3);
    checks++; if (qd_b_o !== 8'h00) begin failures++; $display("FAIL psc_restart got=%h exp=00", qd_b_o); end
    step(1);
    checks++; if (qd_b_o !== 8'h03) begin failures++; $display("FAIL psc_tick got=%h exp=03", qd_b_o); end
  endtask

  initial begin
    test_reset;
    test_count_up;
    test_load_wrap;
    test_down_wrap;
    test_mask_load;
    test_clear_priority;
    test_prescale;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
